// File: rtl/tx_fcs_insert_pkg.sv
// Shared TX-path constants and types: CRC-32 parameters, XGMII control characters,
// FCS inserter state encodings and byte-enable helpers.
package tx_fcs_insert_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;

  typedef enum logic [2:0] {
    ST_SOP   = 3'b001,
    ST_MID   = 3'b010,
    ST_EXTRA = 3'b100
  } fcs_state_e;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic        user;
    logic [7:0]  keep;
    logic [63:0] data;
  } axis_beat_t;

  // Valid byte count = highest set tkeep bit + 1; 0 when tkeep is empty.
  function automatic logic [3:0] keep_to_count(input logic [7:0] keep);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int b = 0; b < 8; b++)
      if (keep[b]) cnt = 4'(b + 1);
    return cnt;
  endfunction

  function automatic logic [7:0] count_to_keep(input logic [3:0] cnt);
    logic [7:0] keep;
    keep = '0;
    for (int b = 0; b < 8; b++)
      keep[b] = (4'(b) < cnt);
    return keep;
  endfunction

  function automatic logic [63:0] keep_to_mask(input logic [7:0] keep);
    logic [63:0] mask;
    mask = '0;
    for (int b = 0; b < 8; b++)
      mask[8*b +: 8] = {8{keep[b]}};
    return mask;
  endfunction

endpackage

// File: rtl/tx_fcs_insert_if.sv
// 64-bit AXI-Stream bundle with a one-bit error sideband.
interface tx_fcs_insert_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/tx_fcs_insert_crc32.sv
// Combinational Ethernet CRC-32 update over the low i_nbytes bytes of a 64-bit word,
// byte0 first, each byte LSB first.
module crc32_d64
  import tx_fcs_insert_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [63:0] i_data,
  input  logic [3:0]  i_nbytes,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  always_comb begin
    // NOTE: blocking assignments here chain the 64 serial steps into one combinational cone.
    w_crc = i_crc;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < i_nbytes) begin
        for (int k = 0; k < 8; k++)
          w_crc = {1'b0, w_crc[31:1]} ^ ((w_crc[0] ^ i_data[8*b + k]) ? CRC32_POLY_REFL : 32'h0);
      end
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/tx_fcs_insert.sv
// Appends the Ethernet FCS to padded 64-bit AXIS frames, spilling into one extra beat
// when the last input beat holds more than four bytes.
module tx_fcs_insert
  import tx_fcs_insert_pkg::*;
#(
  parameter bit          CORRUPT_ON_ERR = 1'b1,
  parameter logic [31:0] CRC_INIT       = CRC32_INIT
) (
  input  logic             clk,
  input  logic             rst,
  tx_fcs_insert_if.slave   s_axis,
  tx_fcs_insert_if.master  m_axis
);

  fcs_state_e  r_state, w_state_nxt;
  logic [31:0] r_crc, w_crc_nxt;
  axis_beat_t  r_out, w_out_nxt;
  axis_beat_t  r_spill, w_spill_nxt;
  logic        r_spill_loaded, w_spill_loaded_nxt;
  logic        r_rdy_en;

  logic        w_out_free, w_out_fire, w_s_tready, w_accept;
  logic [3:0]  w_last_cnt, w_nbytes;
  logic [31:0] w_crc_seed, w_crc_calc, w_fcs;
  logic [63:0] w_fcs_data, w_spill_data;

  assign w_out_free = !r_out.valid || m_axis.tready;
  assign w_out_fire = r_out.valid && m_axis.tready;
  // r_rdy_en keeps tready low through the reset cycle itself.
  assign w_s_tready = r_rdy_en && w_out_free && (r_state != ST_EXTRA);
  assign w_accept   = s_axis.tvalid && w_s_tready;

  assign w_last_cnt = keep_to_count(s_axis.tkeep);
  assign w_nbytes   = s_axis.tlast ? w_last_cnt : 4'd8;
  assign w_crc_seed = (r_state == ST_SOP) ? CRC_INIT : r_crc;

  crc32_d64 u_crc (
    .i_crc    (w_crc_seed),
    .i_data   (s_axis.tdata),
    .i_nbytes (w_nbytes),
    .o_crc    (w_crc_calc)
  );

  assign w_fcs = ~w_crc_calc ^ {32{CORRUPT_ON_ERR & s_axis.tuser}};

  // FCS byte 0 lands right after the last payload byte; whatever does not fit goes to the spill beat.
  assign w_fcs_data   = (s_axis.tdata & keep_to_mask(count_to_keep(w_last_cnt)))
                      | ({32'h0, w_fcs} << {w_last_cnt, 3'b000});
  assign w_spill_data = {32'h0, w_fcs} >> {4'd8 - w_last_cnt, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_state_nxt        = r_state;
    w_crc_nxt          = r_crc;
    w_out_nxt          = r_out;
    w_spill_nxt        = r_spill;
    w_spill_loaded_nxt = r_spill_loaded;
    if (w_out_fire) w_out_nxt.valid = 1'b0;

    case (r_state)
      ST_SOP, ST_MID: begin
        if (w_accept) begin
          if (!s_axis.tlast) begin
            w_out_nxt   = '{valid: 1'b1, last: 1'b0, user: 1'b0, keep: s_axis.tkeep, data: s_axis.tdata};
            w_crc_nxt   = w_crc_calc;
            w_state_nxt = ST_MID;
          end else if (w_last_cnt <= 4'd4) begin
            w_out_nxt   = '{valid: 1'b1, last: 1'b1, user: s_axis.tuser,
                            keep: count_to_keep(4'(w_last_cnt + 4'd4)), data: w_fcs_data};
            w_crc_nxt   = CRC_INIT;
            w_state_nxt = ST_SOP;
          end else begin
            w_out_nxt          = '{valid: 1'b1, last: 1'b0, user: 1'b0, keep: 8'hFF, data: w_fcs_data};
            w_spill_nxt        = '{valid: 1'b1, last: 1'b1, user: s_axis.tuser,
                                   keep: count_to_keep(4'(w_last_cnt - 4'd4)), data: w_spill_data};
            w_spill_loaded_nxt = 1'b0;
            w_crc_nxt          = CRC_INIT;
            w_state_nxt        = ST_EXTRA;
          end
        end
      end
      ST_EXTRA: begin
        if (!r_spill_loaded) begin
          if (w_out_free) begin
            w_out_nxt          = r_spill;
            w_spill_loaded_nxt = 1'b1;
          end
        end else if (w_out_fire) begin
          w_state_nxt = ST_SOP;
        end
      end
      default: w_state_nxt = ST_SOP;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state        <= ST_SOP;
      r_crc          <= CRC_INIT;
      r_out          <= '0;
      r_spill        <= '0;
      r_spill_loaded <= 1'b0;
      r_rdy_en       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_crc          <= w_crc_nxt;
      r_out          <= w_out_nxt;
      r_spill        <= w_spill_nxt;
      r_spill_loaded <= w_spill_loaded_nxt;
      r_rdy_en       <= 1'b1;
    end
  end

  assign s_axis.tready = w_s_tready;
  assign m_axis.tdata  = r_out.data;
  assign m_axis.tkeep  = r_out.keep;
  assign m_axis.tvalid = r_out.valid;
  assign m_axis.tlast  = r_out.last;
  assign m_axis.tuser  = r_out.user;

endmodule

// File: tb/tb_tx_fcs_insert.sv
// Directed and randomised bench for tx_fcs_insert: hand-computed vectors plus a
// byte-stream CRC model that re-beats payload+FCS independently of the RTL datapath.
module tb_tx_fcs_insert;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_fcs_insert_if s_if ();
  tx_fcs_insert_if m_if ();

  tx_fcs_insert dut (
    .clk    (clk),
    .rst    (rst),
    .s_axis (s_if),
    .m_axis (m_if)
  );

  int errors = 0;
  int checks = 0;

  beat_t in_q[$];
  beat_t exp_q[$];
  int ready_pct = 100;
  int gap_pct   = 0;

  int          out_beats;
  logic [63:0] pen_data, last_data;
  logic [7:0]  last_keep;
  logic        last_user;
  logic [63:0] good_pen, good_last;

  function automatic logic [31:0] crc_ref(input logic [7:0] bytes[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bytes[i]) begin
      c = c ^ {24'h0, bytes[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Queues input beats and the expected output (payload ++ FCS, re-split into beats).
  task automatic add_frame(input logic [7:0] bytes[$], input logic user);
    logic [7:0]  out_bytes[$];
    logic [31:0] fcs;
    int          len;
    beat_t       b;
    len = bytes.size();
    for (int i = 0; i < len; i += 8) begin
      b.data = {8{8'hA5}};
      b.keep = '0;
      for (int k = 0; k < 8; k++)
        if (i + k < len) begin
          b.data[8*k +: 8] = bytes[i + k];
          b.keep[k]        = 1'b1;
        end
      b.last = (i + 8 >= len);
      b.user = b.last ? user : 1'b1;
      in_q.push_back(b);
    end
    fcs = ~crc_ref(bytes);
    if (user) fcs = ~fcs;
    out_bytes = bytes;
    for (int k = 0; k < 4; k++) out_bytes.push_back(fcs[8*k +: 8]);
    for (int i = 0; i < out_bytes.size(); i += 8) begin
      b.data = '0;
      b.keep = '0;
      for (int k = 0; k < 8; k++)
        if (i + k < out_bytes.size()) begin
          b.data[8*k +: 8] = out_bytes[i + k];
          b.keep[k]        = 1'b1;
        end
      b.last = (i + 8 >= out_bytes.size());
      b.user = b.last ? user : 1'b0;
      exp_q.push_back(b);
    end
  endtask

  task automatic make_bytes(input int len, input bit rnd, output logic [7:0] bytes[$]);
    bytes.delete();
    for (int i = 0; i < len; i++) bytes.push_back(rnd ? 8'($urandom) : 8'(i + 1));
  endtask

  // Drives in_q and consumes/compares m_axis beats against exp_q, one cycle per iteration.
  task automatic run_traffic(input int max_cycles, output int stalls);
    bit    prev_stall;
    beat_t prev, e;
    int    cyc;
    prev_stall = 1'b0;
    cyc        = 0;
    stalls     = 0;
    out_beats  = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      m_if.tready = ($urandom_range(0, 99) < ready_pct);
      if (in_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        s_if.tvalid = 1'b1;
        s_if.tdata  = in_q[0].data;
        s_if.tkeep  = in_q[0].keep;
        s_if.tlast  = in_q[0].last;
        s_if.tuser  = in_q[0].user;
      end else begin
        s_if.tvalid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if ({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !==
            {1'b1, prev.data, prev.keep, prev.last, prev.user}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h k=%h, held d=%h k=%h",
                   m_if.tvalid, m_if.tdata, m_if.tkeep, prev.data, prev.keep);
        end
      end
      if (s_if.tvalid) begin
        if (s_if.tready) void'(in_q.pop_front());
        else stalls++;
      end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        out_beats++;
        pen_data  = last_data;
        last_data = m_if.tdata;
        last_keep = m_if.tkeep;
        last_user = m_if.tuser;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got d=%h k=%h, none expected", m_if.tdata, m_if.tkeep);
        end else begin
          e = exp_q.pop_front();
          if (m_if.tdata !== e.data || m_if.tkeep !== e.keep ||
              m_if.tlast !== e.last || m_if.tuser !== e.user) begin
            errors++;
            $display("FAIL out_beat: got d=%h k=%h l=%b u=%b, exp d=%h k=%h l=%b u=%b",
                     m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, e.data, e.keep, e.last, e.user);
          end
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev       = '{data: m_if.tdata, keep: m_if.tkeep, last: m_if.tlast, user: m_if.tuser};
    end
    checks++;
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      errors++;
      $display("FAIL timeout: in_left=%0d out_left=%0d, required 0/0", in_q.size(), exp_q.size());
      in_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    #1;
    checks++;
    if (m_if.tvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drain: got tvalid=%b, required 0", m_if.tvalid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks += 6;
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", m_if.tvalid); end
    if (m_if.tlast  !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b, required 0", m_if.tlast); end
    if (m_if.tuser  !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b, required 0", m_if.tuser); end
    if (m_if.tkeep  !== 8'h0) begin errors++; $display("FAIL rst_tkeep: got %h, required 00", m_if.tkeep); end
    if (m_if.tdata  !== 64'h0) begin errors++; $display("FAIL rst_tdata: got %h, required 0", m_if.tdata); end
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b, required 0", s_if.tready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL tready_before_edge: got %b, required 0", s_if.tready); end
    @(negedge clk);
    #1;
    checks++;
    if (s_if.tready !== 1'b1) begin errors++; $display("FAIL tready_after_rst: got %b, required 1", s_if.tready); end
  endtask

  task automatic test_check_value;
    int stalls;
    ready_pct = 100; gap_pct = 0;
    in_q.push_back('{data: 64'h3837363534333231, keep: 8'hFF, last: 1'b0, user: 1'b0});
    in_q.push_back('{data: 64'hA5A5A5A5A5A5A539, keep: 8'h01, last: 1'b1, user: 1'b0});
    exp_q.push_back('{data: 64'h3837363534333231, keep: 8'hFF, last: 1'b0, user: 1'b0});
    exp_q.push_back('{data: 64'h000000CBF4392639, keep: 8'h1F, last: 1'b1, user: 1'b0});
    run_traffic(100, stalls);
  endtask

  task automatic test_min_frame;
    logic [7:0] bytes[$];
    int stalls;
    ready_pct = 100; gap_pct = 0;
    make_bytes(60, 1'b0, bytes);
    add_frame(bytes, 1'b0);
    run_traffic(200, stalls);
    checks += 3;
    if (out_beats !== 8) begin errors++; $display("FAIL min_beats: got %0d, required 8", out_beats); end
    if (last_keep !== 8'hFF) begin errors++; $display("FAIL min_last_keep: got %h, required FF", last_keep); end
    if (stalls !== 0) begin errors++; $display("FAIL min_stalls: got %0d, required 0", stalls); end
  endtask

  task automatic test_spill;
    logic [7:0] bytes[$];
    int stalls;
    ready_pct = 100; gap_pct = 0;
    make_bytes(61, 1'b0, bytes);
    add_frame(bytes, 1'b0);
    run_traffic(200, stalls);
    good_pen  = pen_data;
    good_last = last_data;
    checks += 3;
    if (out_beats !== 9) begin errors++; $display("FAIL spill_beats: got %0d, required 9", out_beats); end
    if (last_keep !== 8'h01) begin errors++; $display("FAIL spill_keep: got %h, required 01", last_keep); end
    if (last_user !== 1'b0) begin errors++; $display("FAIL spill_user: got %b, required 0", last_user); end
  endtask

  task automatic test_err_frame;
    logic [7:0] bytes[$];
    int stalls;
    ready_pct = 100; gap_pct = 0;
    make_bytes(61, 1'b0, bytes);
    add_frame(bytes, 1'b1);
    run_traffic(200, stalls);
    checks += 3;
    if (pen_data[63:40] !== ~good_pen[63:40]) begin
      errors++; $display("FAIL err_frag0: got %h, required %h", pen_data[63:40], ~good_pen[63:40]);
    end
    if (last_data[7:0] !== ~good_last[7:0]) begin
      errors++; $display("FAIL err_frag1: got %h, required %h", last_data[7:0], ~good_last[7:0]);
    end
    if (last_user !== 1'b1) begin errors++; $display("FAIL err_user: got %b, required 1", last_user); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[$];
    int stalls;
    ready_pct = 100; gap_pct = 0;
    make_bytes(60, 1'b1, bytes); add_frame(bytes, 1'b0);
    make_bytes(60, 1'b1, bytes); add_frame(bytes, 1'b1);
    make_bytes(61, 1'b1, bytes); add_frame(bytes, 1'b0);
    make_bytes(64, 1'b1, bytes); add_frame(bytes, 1'b0);
    make_bytes(60, 1'b1, bytes); add_frame(bytes, 1'b0);
    run_traffic(400, stalls);
    checks += 2;
    if (stalls !== 4) begin errors++; $display("FAIL b2b_stalls: got %0d, required 4", stalls); end
    if (out_beats !== 8 + 8 + 9 + 9 + 8) begin
      errors++; $display("FAIL b2b_beats: got %0d, required 42", out_beats);
    end
  endtask

  task automatic test_random;
    logic [7:0] bytes[$];
    int stalls, len;
    ready_pct = 50; gap_pct = 30;
    for (int f = 0; f < 120; f++) begin
      len = (f % 10 == 9) ? int'($urandom_range(60, 1518)) : int'($urandom_range(60, 80));
      make_bytes(len, 1'b1, bytes);
      add_frame(bytes, ($urandom_range(0, 3) == 0));
    end
    run_traffic(60000, stalls);
  endtask

  task automatic test_reset_mid;
    logic [7:0] bytes[$];
    int stalls;
    ready_pct = 100; gap_pct = 0;
    make_bytes(100, 1'b1, bytes);
    add_frame(bytes, 1'b0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = in_q[i].data;
      s_if.tkeep  = in_q[i].keep;
      s_if.tlast  = in_q[i].last;
      s_if.tuser  = in_q[i].user;
      if (i == 3) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    checks += 2;
    if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b, required 0", m_if.tvalid); end
    if (s_if.tready !== 1'b0) begin errors++; $display("FAIL midrst_tready: got %b, required 0", s_if.tready); end
    @(negedge clk);
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    in_q.delete();
    exp_q.delete();
    @(negedge clk);
    make_bytes(70, 1'b1, bytes);
    add_frame(bytes, 1'b0);
    run_traffic(200, stalls);
    checks++;
    if (out_beats !== 10) begin errors++; $display("FAIL midrst_beats: got %0d, required 10", out_beats); end
  endtask

  initial begin
    test_reset();
    test_check_value();
    test_min_frame();
    test_spill();
    test_err_frame();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
